bram_dma_engine: RTL

Single-channel block-copy/fill engine driving one port of the 64 KB lower-RAM block RAM. It sits directly upstream of that RAM port, issuing address, write-enable and write-data, and consuming the RAM's registered read data. Software or the CPU-side controller programs source, destination, length and mode, then pulses `start`. The engine reports completion with a one-cycle `done` pulse.

---
 rtl/bram_dma_engine.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bram_dma_engine.sv
// -----------------------------------------------------------------------------
// bram_dma_engine
// Single-channel block copy / fill engine that drives one port of the 64 KB
// lower-RAM block RAM. The controller programs src/dst/len/mode/fill_val and
// pulses start; the engine walks the RAM port and reports completion with a
// one-cycle done pulse.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin an operation (accepted only in IDLE)
//   mode       in   0 = copy src->dst, 1 = fill dst with fill_val
//   src        in   copy source start address
//   dst        in   destination start address
//   len        in   byte count, 0 = no-op
//   fill_val   in   fill byte
//   busy       out  high while reading/writing
//   done       out  one-cycle completion pulse
//   ram_addr   out  RAM port address
//   ram_we     out  RAM port write enable
//   ram_di     out  RAM port write data
//   ram_do     in   RAM port read data (one-cycle registered latency)
//   state_dbg  out  current FSM state (IDLE=0, RD=1, WR=2, DONE=3)
//
// Handshake: start is a request that is accepted only on a cycle where the
// engine is in IDLE (busy=0 and done=0); requests at any other time are
// dropped, not queued. Every accepted request produces exactly one done pulse
// unless rst intervenes, in which case no done pulse is produced.
// -----------------------------------------------------------------------------
module bram_dma_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_do,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_r;
   logic [ADDR_W-1:0] dst_r;
   logic [ADDR_W-1:0] cnt;
   logic              mode_r;
   logic [DATA_W-1:0] fill_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         src_r  <= '0;
         dst_r  <= '0;
         cnt    <= '0;
         mode_r <= 1'b0;
         fill_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_r  <= src;
                  dst_r  <= dst;
                  cnt    <= len;
                  mode_r <= mode;
                  fill_r <= fill_val;
                  if (len == '0)
                     state <= DONE;
                  else if (mode)
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD: begin
               src_r <= src_r + 1'b1;
               state <= WR;
            end
            WR: begin
               dst_r <= dst_r + 1'b1;
               cnt   <= cnt - 1'b1;
               // cnt is sampled before the decrement: 1 means this is the last byte
               if (cnt == {{(ADDR_W-1){1'b0}}, 1'b1})
                  state <= DONE;
               else if (mode_r)
                  state <= WR;
               else
                  state <= RD;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM-side outputs decode from state registers only; start/src/dst/len
   // never reach them combinationally. rst gates the write enable so that a
   // reset cycle can never commit a write.
   always_comb begin
      busy      = (state == RD) || (state == WR);
      done      = (state == DONE);
      ram_addr  = (state == RD) ? src_r : dst_r;
      ram_we    = (state == WR) && !rst;
      // copy forwards the byte fetched in the preceding RD cycle
      ram_di    = ((state == WR) && !mode_r) ? ram_do : fill_r;
      state_dbg = state;
   end

endmodule
